// File: rtl/data_sram_responder.sv
// ---------------------------------------------------------------------------
// data_sram_responder
//
// Responder side of an SRAM-style memory port (en/we/addr/wdata -> rdata).
// Holds DEPTH = 2**ADDR_W 32-bit words, supports byte-lane writes and returns
// read data with a fixed one-cycle latency. After every reset an init FSM
// writes zero to the whole array before requests are accepted. Accesses that
// are misaligned or fall outside the address window are flagged.
//
// Optional feature macro: SRAM_RESP_STATS_EN
//   When defined, adds the rd_cnt/wr_cnt ports. These are saturating counters
//   of accepted reads/writes (good or bad) in RUN.
//
// Ports
//   clk         in   1   clock, all state updates on posedge
//   reset       in   1   asynchronous, active-high reset
//   sram_en     in   1   request valid this cycle
//   sram_we     in   4   byte write enables, 4'b0000 = read
//   sram_addr   in   32  byte address
//   sram_wdata  in   32  write data
//   sram_rdata  out  32  read data, 1 cycle after an accepted read, then held
//   init_busy   out  1   high while the clear FSM runs (requests dropped)
//   addr_err    out  1   sticky flag: a bad access was seen since reset
//   rd_cnt      out  32  accepted reads  (SRAM_RESP_STATS_EN only)
//   wr_cnt      out  32  accepted writes (SRAM_RESP_STATS_EN only)
//
// FSM states
//   state   | meaning
//   ST_INIT | zero-clearing mem[clr_idx], one word per cycle, requests dropped
//   ST_RUN  | serving requests, left only through reset
// ---------------------------------------------------------------------------
module data_sram_responder #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_en,
    input  logic [3:0]  sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        init_busy,
    output logic        addr_err
`ifdef SRAM_RESP_STATS_EN
    ,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    // Window size in bytes. It is kept at 33 bits so that ADDR_W = 30
    // (a 4 GiB window) does not overflow.
    localparam logic [32:0] WIN_BYTES = 33'd4 << ADDR_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] clr_idx_nxt;

    logic [31:0]       mem [DEPTH];

    logic [31:0]       off;
    logic [ADDR_W-1:0] idx;
    logic              bad;

    logic              acc_rd;
    logic              acc_wr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_idx;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;

    // Address decode. The offset wraps at 32 bits, so an address below
    // BASE_ADDR produces a large offset and is rejected by the range check.
    assign off = sram_addr - BASE_ADDR;
    assign idx = off[ADDR_W+1:2];
    assign bad = (off[1:0] != 2'b00) | ({1'b0, off} >= WIN_BYTES);

    assign init_busy = (state == ST_INIT);

    // Next-state and memory-port steering. The single memory write port is
    // shared between the clear sweep and normal writes.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        acc_rd      = 1'b0;
        acc_wr      = 1'b0;
        mem_we      = 1'b0;
        mem_idx     = idx;
        mem_be      = sram_we;
        mem_wdata   = sram_wdata;

        case (state)
            ST_INIT: begin
                mem_we      = 1'b1;
                mem_idx     = clr_idx;
                mem_be      = 4'hF;
                mem_wdata   = 32'h0000_0000;
                clr_idx_nxt = clr_idx + 1'b1;
                if (&clr_idx) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sram_en) begin
                    if (sram_we == 4'b0000) begin
                        acc_rd = 1'b1;
                    end else begin
                        acc_wr = 1'b1;
                        mem_we = !bad;
                    end
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // The storage array has no reset. Its contents are defined by the clear
    // sweep that follows every reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_INIT;
            clr_idx    <= '0;
            sram_rdata <= 32'h0000_0000;
            addr_err   <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
            if (acc_rd) begin
                sram_rdata <= bad ? ERR_DATA : mem[idx];
            end
            if ((acc_rd | acc_wr) & bad) begin
                addr_err <= 1'b1;
            end
        end
    end

`ifdef SRAM_RESP_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt <= 32'h0000_0000;
            wr_cnt <= 32'h0000_0000;
        end else begin
            if (acc_rd && (rd_cnt != 32'hFFFF_FFFF)) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (acc_wr && (wr_cnt != 32'hFFFF_FFFF)) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
